// File: rtl/async_pkg.sv
// Shared types for the clocked 4-phase handshake splitter.
package async_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_RTZ} split_state_t;

  function automatic logic [1:0] lane_onehot(input logic lane);
    return lane ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer for an asynchronous single-bit input, cleared by sync reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
    end else begin
      r_sh[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_sh[i] <= r_sh[i-1];
      end
    end
  end

  assign q = r_sh[STAGES-1];

endmodule

// File: rtl/hs_split_2b.sv
// 4-phase handshake splitter: routes one bundled-data request channel to one of two
// downstream lanes selected by sel, completing return-to-zero on both sides.
module hs_split_2b
  import async_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  output logic              ack_in,
  input  logic              sel,
  input  logic [DATA_W-1:0] data_in,
  output logic [1:0]        req_out,
  input  logic [1:0]        ack_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              timeout
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  split_state_t      r_state;
  logic              r_sel_q;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_req_out;
  logic              r_ack_in;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_timeout;

  logic       w_req_s;
  logic [1:0] w_ack_s;
  logic       w_ack_sel;
  logic       w_advance;
  logic       w_in_wait;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req  (.clk(clk), .rst(rst), .d(req_in),     .q(w_req_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack0 (.clk(clk), .rst(rst), .d(ack_out[0]), .q(w_ack_s[0]));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack1 (.clk(clk), .rst(rst), .d(ack_out[1]), .q(w_ack_s[1]));

  // Only the captured lane's acknowledge is ever observed.
  assign w_ack_sel = r_sel_q ? w_ack_s[1] : w_ack_s[0];
  assign w_in_wait = (r_state == S_REQ) || (r_state == S_RTZ);

  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      S_IDLE:  w_advance = w_req_s;
      S_REQ:   w_advance = w_ack_sel;
      S_ACK:   w_advance = !w_req_s;
      S_RTZ:   w_advance = !w_ack_sel;
      default: w_advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel_q   <= 1'b0;
      r_data    <= '0;
      r_req_out <= 2'b00;
      r_ack_in  <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_advance) begin
        case (r_state)
          S_IDLE: begin
            r_sel_q   <= sel;
            r_data    <= data_in;
            r_req_out <= lane_onehot(sel);
            r_busy    <= 1'b1;
            r_state   <= S_REQ;
          end
          S_REQ: begin
            r_ack_in <= 1'b1;
            r_state  <= S_ACK;
          end
          S_ACK: begin
            r_req_out <= 2'b00;
            r_state   <= S_RTZ;
          end
          default: begin
            r_ack_in <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        endcase
      end

      // Wait-time counter restarts on every transition and never aborts a transfer.
      if (w_advance) begin
        r_cnt <= '0;
      end else if (w_in_wait && (r_cnt != CNT_SAT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((TIMEOUT != 0) && w_in_wait && (r_cnt == CNT_LAST)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign req_out  = r_req_out;
  assign ack_in   = r_ack_in;
  assign data_out = r_data;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule
